sr_latch_driver: RTL and testbench

Upstream drive stage for the gated SR latch in this directory. It synchronises and debounces two raw push-button inputs (set and reset) and turns each debounced press into a clean, fixed-width S or R pulse. The block guarantees that S and R are never asserted together, so the latch never sees the forbidden input. A busy/gap sequencer spaces the pulses, and a one-deep pending slot per input catches presses that arrive while a pulse is in progress.

---
 rtl/sr_latch_driver_if.sv | 20 ++
 rtl/sr_latch_driver.sv | 130 +++++++++++++
 tb/tb_sr_latch_driver.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_driver_if.sv
// Button inputs and latch drive outputs of the SR latch driver.
// The master side owns the buttons; the slave side drives S/R.
interface sr_latch_driver_if;
  logic set_btn;
  logic rst_btn;
  logic S;
  logic R;
  logic busy;
  logic conflict;

  modport master (
    output set_btn, rst_btn,
    input  S, R, busy, conflict
  );

  modport slave (
    input  set_btn, rst_btn,
    output S, R, busy, conflict
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Synchronises and debounces set/reset buttons and sequences
// non-overlapping fixed-width S/R pulses for a gated SR latch.
module sr_latch_driver #(
  parameter int DB_CYCLES    = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input logic              clk,
  input logic              reset,
  sr_latch_driver_if.slave bus
);

  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int PMAX = (PULSE_CYCLES > GAP_CYCLES) ?
                        PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(PMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SET_P,
    RST_P,
    GAP
  } state_t;

  // bit 0 = set path, bit 1 = reset path
  logic [1:0]    btn;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_prev;
  logic [1:0]    req;
  logic [1:0]    src;
  logic [1:0]    pend;
  logic [DW-1:0] db_cnt [2];
  logic [CW-1:0] cnt;
  state_t        state;

  assign btn = {bus.rst_btn, bus.set_btn};
  assign req = db & ~db_prev;
  assign src = req | pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      db_prev   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      db_prev <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pend         <= '0;
      bus.S        <= 1'b0;
      bus.R        <= 1'b0;
      bus.busy     <= 1'b0;
      bus.conflict <= 1'b0;
    end else begin
      bus.conflict <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          // reset dominates; a coincident set is dropped
          if (src[1]) begin
            state        <= RST_P;
            pend         <= '0;
            bus.R        <= 1'b1;
            bus.busy     <= 1'b1;
            bus.conflict <= src[0];
          end else if (src[0]) begin
            state    <= SET_P;
            pend     <= '0;
            bus.S    <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        SET_P, RST_P: begin
          pend <= pend | req;
          if (cnt == P_LAST) begin
            cnt   <= '0;
            bus.S <= 1'b0;
            bus.R <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          pend <= pend | req;
          if (cnt == G_LAST) begin
            cnt      <= '0;
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: directed scenarios followed
// by randomized button activity against a timing-level reference model.
module tb_sr_latch_driver;

  localparam int DB = 4;
  localparam int P  = 2;
  localparam int G  = 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sr_latch_driver_if ifc ();

  sr_latch_driver #(
    .DB_CYCLES   (DB),
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit is_rst;
    bit conf;
    int start_cyc;
  } pulse_t;

  pulse_t sb[$];

  // Reference model: button pipeline as plain variables, the pulse
  // sequencer as "next free edge" arithmetic.
  int       cyc = 0;
  bit [1:0] m_s1, m_s2, m_db, m_dbp, m_pend;
  int       m_run [2];
  int       free_at;
  bit       have_cur, cur_rst, cur_conf;
  int       cur_start;
  bit [3:0] m_exp;

  always @(posedge clk) begin : model
    bit [1:0] rq;
    bit [1:0] src;
    bit [1:0] raw;
    bit [1:0] ndb;
    int       d;
    cyc++;
    if (!reset) begin
      m_s1     = '0;
      m_s2     = '0;
      m_db     = '0;
      m_dbp    = '0;
      m_pend   = '0;
      m_run    = '{0, 0};
      free_at  = 0;
      have_cur = 0;
    end else begin
      raw = {ifc.rst_btn, ifc.set_btn};
      ndb = m_db;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            ndb[i]   = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      rq    = m_db & ~m_dbp;
      m_dbp = m_db;
      m_db  = ndb;
      m_s2  = m_s1;
      m_s1  = raw;
      if (cyc >= free_at) begin
        src = rq | m_pend;
        if (src != 2'b00) begin
          have_cur  = 1;
          cur_rst   = src[1];
          cur_conf  = (src == 2'b11);
          cur_start = cyc;
          free_at   = cyc + P + G + 1;
          m_pend    = '0;
          sb.push_back('{cur_rst, cur_conf, cyc});
        end
      end else begin
        m_pend = m_pend | rq;
      end
    end
    d     = cyc - cur_start;
    m_exp = '0;
    if (have_cur) begin
      m_exp[3] = !cur_rst && (d < P);
      m_exp[2] = cur_rst && (d < P);
      m_exp[1] = (d < P + G);
      m_exp[0] = cur_conf && (d == 0);
    end
  end

  bit pS = 0;
  bit pR = 0;

  always @(posedge clk) begin : monitor
    pulse_t   e;
    bit [3:0] act;
    #1;
    act = {ifc.S, ifc.R, ifc.busy, ifc.conflict};
    check("cycle_outputs", 32'(act), 32'(m_exp));
    if ((ifc.S && !pS) || (ifc.R && !pR)) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        pops++;
        check("sb_kind", 32'(ifc.R), 32'(e.is_rst));
        check("sb_start", 32'(cyc), 32'(e.start_cyc));
        check("sb_conflict", 32'(ifc.conflict), 32'(e.conf));
      end
    end
    pS = ifc.S;
    pR = ifc.R;
  end

  logic [31:0] cS, cR, cB, cC;

  task automatic capture(input int start, input int n);
    if (start == 0) begin
      cS = '0;
      cR = '0;
      cB = '0;
      cC = '0;
    end
    for (int k = start; k < start + n; k++) begin
      @(posedge clk);
      #1;
      cS[k] = ifc.S;
      cR[k] = ifc.R;
      cB[k] = ifc.busy;
      cC[k] = ifc.conflict;
    end
  endtask

  function automatic logic [31:0] win(input int lo, input int hi);
    logic [31:0] w;
    w = '0;
    for (int k = lo; k <= hi; k++) w[k] = 1'b1;
    return w;
  endfunction

  task automatic drive(input bit s, input bit r);
    @(negedge clk);
    ifc.set_btn = s;
    ifc.rst_btn = r;
  endtask

  task automatic idle();
    drive(0, 0);
    repeat (20) @(posedge clk);
  endtask

  initial begin
    bit anyr;
    int hs;
    int hr;
    bit ls;
    bit lr;
    reset       = 1'b0;
    ifc.set_btn = 1'b1;
    ifc.rst_btn = 1'b1;

    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold",
            32'({ifc.S, ifc.R, ifc.busy, ifc.conflict}), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    capture(0, 12);
    check("fresh_R", cR, win(6, 7));
    check("fresh_S", cS, 32'd0);
    check("fresh_conflict", cC, win(6, 6));
    check("fresh_busy", cB, win(6, 8));

    idle();
    drive(1, 0);
    capture(0, 14);
    check("set_S", cS, win(6, 7));
    check("set_R", cR, 32'd0);
    check("set_busy", cB, win(6, 8));
    check("set_conflict", cC, 32'd0);

    idle();
    anyr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ifc.rst_btn = (k % 2 == 0);
      @(posedge clk);
      #1;
      anyr = anyr | ifc.R | ifc.busy;
    end
    drive(0, 0);
    capture(0, 16);
    check("bounce_R", {cR[30:0], anyr}, 32'd0);
    check("bounce_busy", cB, 32'd0);

    idle();
    drive(1, 1);
    capture(0, 14);
    check("both_R", cR, win(6, 7));
    check("both_S", cS, 32'd0);
    check("both_conflict", cC, win(6, 6));
    check("both_busy", cB, win(6, 8));

    idle();
    drive(1, 0);
    capture(0, 1);
    @(negedge clk);
    ifc.rst_btn = 1'b1;
    capture(1, 15);
    check("pend_S", cS, win(6, 7));
    check("pend_R", cR, win(10, 11));
    check("pend_busy", cB, win(6, 8) | win(10, 12));
    check("pend_overlap", cS & cR, 32'd0);

    idle();
    drive(1, 0);
    capture(0, 7);
    check("mid_S_up", 32'(cS[6]), 32'd1);
    @(negedge clk);
    reset       = 1'b0;
    ifc.set_btn = 1'b0;
    #1;
    check("mid_async_clear", 32'({ifc.S, ifc.busy}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    capture(0, 16);
    check("mid_no_resume_S", cS, 32'd0);
    check("mid_no_resume_busy", cB, 32'd0);

    hs = 0;
    hr = 0;
    ls = 0;
    lr = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (hs == 0) begin
        ls = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 10);
      end
      if (hr == 0) begin
        lr = 1'($urandom_range(0, 1));
        hr = $urandom_range(1, 10);
      end
      hs--;
      hr--;
      ifc.set_btn = ls;
      ifc.rst_btn = lr;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 399) == 0) reset = 1'b0;
    end

    @(negedge clk);
    reset       = 1'b1;
    ifc.set_btn = 1'b0;
    ifc.rst_btn = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("sb_pulses_seen", 32'(pops > 10), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
